reorder_buffer: RTL and testbench
=================================

Name: reorder_buffer

Overview:
- In-order retirement buffer for the Tomasulo core; the producer end of the launch/commit interface the register file consumes.
- Allocates one entry per issued instruction and drives the rename launch (rd -> ROB id) to the register file in the same cycle.
- Captures CDB writebacks and retires completed entries in program order as single-cycle commit pulses.
- On a branch mispredict detected at commit, drives the global _clear and the redirect PC.

Parameters:
- DEPTH, 31, number of entries; ROB ids are 1..DEPTH, id 0 is reserved for "no dependency"; DEPTH must be ≤ 2^ID_W-1.
- ID_W, 5, ROB id width.

Ports:
- clk_in input 1 system clock.
- rst_in input 1 reset, asynchronous, active-high.
- rdy_in input 1 when low, all state and outputs hold.
- _issue_valid input 1 decoder offers an instruction.
- _issue_rd input 5 destination register; 0 = none.
- _issue_is_branch input 1 entry is a conditional branch.
- _issue_pred_taken input 1 predicted direction.
- _rob_full output 1 count==DEPTH; combinational.
- _rob_tail_id output ID_W id the next issued instruction receives.
- _rob_launch_ready output 1 combinational launch strobe to the register file.
- _rob_launch_rob_id output 5 equals _rob_tail_id.
- _rob_launch_register_id output 5 equals _issue_rd.
- _wb_valid input 1 CDB result valid.
- _wb_rob_id input ID_W producing entry.
- _wb_value input 32 result value.
- _wb_taken input 1 actual branch direction.
- _wb_target input 32 correct next PC if mispredicted.
- _query_id_1 input ID_W operand-1 lookup id.
- _query_ready_1 output 1 entry busy and ready; combinational.
- _query_value_1 output 32 entry value.
- _query_id_2 input ID_W operand-2 lookup id.
- _query_ready_2 output 1 entry busy and ready; combinational.
- _query_value_2 output 32 entry value.
- _rob_commit_ready output 1 registered commit pulse.
- _rob_commit_rob_id output 5 committed id.
- _rob_commit_register_id output 5 committed rd.
- _rob_commit_value output 32 committed value.
- _clear output 1 registered one-cycle flush pulse.
- _clear_pc output 32 redirect PC, valid while _clear=1.

Behaviour:
- Entry fields: busy, ready, rd, value, is_branch, pred_taken, taken, target.
- State: head, tail (init 1), count 0..DEPTH.
- Reset:
  - All busy/ready cleared; head=tail=1; count=0.
  - _rob_commit_ready=0, _clear=0.
  - All id/value/pc outputs 0.
- All updates occur only when rdy_in=1 and rst_in=0.
- Issue:
  - Accepted when _issue_valid and !_rob_full and !_clear.
  - Sets entry[tail] busy=1, ready=0 and stores the issue fields.
  - tail increments; wraps DEPTH->1, never to 0.
  - _rob_launch_ready = _issue_valid & !_rob_full & !_clear & rdy_in.
- Writeback:
  - If _wb_valid and entry[_wb_rob_id] is busy: set ready, value, taken, target.
  - Writeback to a non-busy id or id 0 is ignored.
- Commit:
  - Occurs when count>0 and entry[head] is busy and ready; at most one per cycle.
  - Next edge: _rob_commit_ready=1 with head id, rd, value.
  - Entry freed; head wraps as tail does.
  - Otherwise _rob_commit_ready=0 next edge.
  - rd=0 entries still pulse with register id 0; the register file ignores them.
- Latency: a writeback at edge N to the head entry produces the commit pulse at edge N+1; there is no same-cycle bypass.
- Mispredict (committing entry is_branch and taken != pred_taken):
  - Commit pulse is emitted normally.
  - Same edge: _clear=1, _clear_pc=target.
  - During the _clear cycle, issue and writeback are ignored.
  - At the edge ending the _clear cycle: all entries cleared, head=tail=1, count=0, _clear returns to 0.
- Count on simultaneous events:
  - Issue and commit in the same cycle: count unchanged.
  - Issue only: +1. Commit only: -1.
- Full: issue ignored and no launch; a commit in that cycle frees a slot for the next cycle only.
- Queries:
  - Report ready=1 only if the entry is busy and ready.
  - A same-cycle writeback is not forwarded.
  - Query id 0 returns ready=0, value 0.
- Reset asserted mid-operation: immediate return to the reset state regardless of clk_in.

Optional Feature:
- Macro: ROB_PERF_COUNTERS_EN.
- When defined:
  - Adds output _perf_commits (32): increments on each commit pulse.
  - Adds output _perf_flushes (32): increments on each _clear.
  - Both reset to 0, wrap at 2^32, hold when rdy_in=0.
- When undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset, issue rd=5 -> launch_ready=1, rob_id=1, reg=5. Then wb id1 value 0xDEAD -> next edge commit_ready=1, id1, reg5, value 0xDEAD. count returns to 0.
- Issue 31 instructions with no wb -> _rob_full=1; 32nd issue gives no launch. wb to id1 -> id1 commits, full deasserts, tail wraps to 1, next issue gets id 1.
- Issue ids 1,2,3; wb order 3,2,1 -> commits strictly 1,2,3 on consecutive edges after wb of id1.
- Branch at id1 pred_taken=0, wb taken=1, target 0x100 -> commit pulse and _clear=1 with _clear_pc=0x100 on the same edge. Next cycle count=0 and tail id 1; issue during the _clear cycle produces no launch.
- Issue id4 then wb id4 value 7 -> query_id_1=4 gives ready=1, value 7; query id 0 gives ready 0. rdy_in=0 for 3 cycles during a pending commit -> no state change; commit occurs after rdy_in returns.
- Async rst_in pulse between clock edges with 5 entries busy -> outputs 0 immediately; the following issue gets id 1.

Source files
------------

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates on issue, captures CDB writebacks, commits in program order.
// Optional ROB_PERF_COUNTERS_EN adds commit/flush performance counters.
module reorder_buffer #(
    parameter int DEPTH = 31,
    parameter int ID_W  = 5
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            rdy_in,
    input  logic            _issue_valid,
    input  logic [4:0]      _issue_rd,
    input  logic            _issue_is_branch,
    input  logic            _issue_pred_taken,
    output logic            _rob_full,
    output logic [ID_W-1:0] _rob_tail_id,
    output logic            _rob_launch_ready,
    output logic [ID_W-1:0] _rob_launch_rob_id,
    output logic [4:0]      _rob_launch_register_id,
    input  logic            _wb_valid,
    input  logic [ID_W-1:0] _wb_rob_id,
    input  logic [31:0]     _wb_value,
    input  logic            _wb_taken,
    input  logic [31:0]     _wb_target,
    input  logic [ID_W-1:0] _query_id_1,
    output logic            _query_ready_1,
    output logic [31:0]     _query_value_1,
    input  logic [ID_W-1:0] _query_id_2,
    output logic            _query_ready_2,
    output logic [31:0]     _query_value_2,
    output logic            _rob_commit_ready,
    output logic [ID_W-1:0] _rob_commit_rob_id,
    output logic [4:0]      _rob_commit_register_id,
    output logic [31:0]     _rob_commit_value,
`ifdef ROB_PERF_COUNTERS_EN
    output logic [31:0]     _perf_commits,
    output logic [31:0]     _perf_flushes,
`endif
    output logic            _clear,
    output logic [31:0]     _clear_pc
);
    localparam int NENT = 1 << ID_W;
    localparam logic [ID_W-1:0] FIRST = ID_W'(1);
    localparam logic [ID_W-1:0] LAST  = ID_W'(DEPTH);

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] value;
        logic        is_branch;
        logic        pred_taken;
        logic        taken;
        logic [31:0] target;
    } ent_t;

    // Slot 0 and slots above DEPTH exist only so any ID_W-bit id indexes safely; they are never busy.
    logic [NENT-1:0] busy_q, busy_d, ready_q, ready_d;
    ent_t            ent_q [NENT];
    ent_t            ent_d [NENT];
    logic [ID_W-1:0] head_q, head_d, tail_q, tail_d, count_q, count_d;
    logic            commit_ready_q, commit_ready_d, clear_q, clear_d;
    logic [ID_W-1:0] commit_id_q, commit_id_d;
    logic [4:0]      commit_reg_q, commit_reg_d;
    logic [31:0]     commit_value_q, commit_value_d, clear_pc_q, clear_pc_d;
    logic            issue_acc, wb_acc, commit_go, mispredict;

    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] p);
        return (p == LAST) ? FIRST : p + FIRST;
    endfunction

    assign _rob_full = (count_q == LAST);
    assign issue_acc = rdy_in & _issue_valid & ~_rob_full & ~clear_q;
    assign wb_acc    = rdy_in & _wb_valid & ~clear_q & (_wb_rob_id != '0) & busy_q[_wb_rob_id];
    assign commit_go = rdy_in & ~clear_q & (count_q != '0) & busy_q[head_q] & ready_q[head_q];
    assign mispredict = commit_go & ent_q[head_q].is_branch
                        & (ent_q[head_q].taken != ent_q[head_q].pred_taken);

    assign _rob_tail_id           = tail_q;
    assign _rob_launch_ready      = issue_acc;
    assign _rob_launch_rob_id     = tail_q;
    assign _rob_launch_register_id = _issue_rd;

    // Queries see registered state only; a same-cycle writeback is not forwarded.
    assign _query_ready_1 = (_query_id_1 != '0) & busy_q[_query_id_1] & ready_q[_query_id_1];
    assign _query_value_1 = (_query_id_1 != '0) ? ent_q[_query_id_1].value : 32'h0;
    assign _query_ready_2 = (_query_id_2 != '0) & busy_q[_query_id_2] & ready_q[_query_id_2];
    assign _query_value_2 = (_query_id_2 != '0) ? ent_q[_query_id_2].value : 32'h0;

    assign _rob_commit_ready       = commit_ready_q;
    assign _rob_commit_rob_id      = commit_id_q;
    assign _rob_commit_register_id = commit_reg_q;
    assign _rob_commit_value       = commit_value_q;
    assign _clear                  = clear_q;
    assign _clear_pc               = clear_pc_q;

    always_comb begin
        busy_d         = busy_q;
        ready_d        = ready_q;
        ent_d          = ent_q;
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        commit_ready_d = commit_ready_q;
        commit_id_d    = commit_id_q;
        commit_reg_d   = commit_reg_q;
        commit_value_d = commit_value_q;
        clear_d        = clear_q;
        clear_pc_d     = clear_pc_q;
        if (rdy_in) begin
            if (clear_q) begin
                busy_d         = '0;
                ready_d        = '0;
                head_d         = FIRST;
                tail_d         = FIRST;
                count_d        = '0;
                clear_d        = 1'b0;
                commit_ready_d = 1'b0;
            end else begin
                if (issue_acc) begin
                    busy_d[tail_q]            = 1'b1;
                    ready_d[tail_q]           = 1'b0;
                    ent_d[tail_q].rd          = _issue_rd;
                    ent_d[tail_q].is_branch   = _issue_is_branch;
                    ent_d[tail_q].pred_taken  = _issue_pred_taken;
                    tail_d                    = wrap_inc(tail_q);
                end
                if (wb_acc) begin
                    ready_d[_wb_rob_id]        = 1'b1;
                    ent_d[_wb_rob_id].value    = _wb_value;
                    ent_d[_wb_rob_id].taken    = _wb_taken;
                    ent_d[_wb_rob_id].target   = _wb_target;
                end
                commit_ready_d = commit_go;
                clear_d        = mispredict;
                if (commit_go) begin
                    busy_d[head_q]  = 1'b0;
                    ready_d[head_q] = 1'b0;
                    head_d          = wrap_inc(head_q);
                    commit_id_d     = head_q;
                    commit_reg_d    = ent_q[head_q].rd;
                    commit_value_d  = ent_q[head_q].value;
                end
                if (mispredict) clear_pc_d = ent_q[head_q].target;
                case ({issue_acc, commit_go})
                    2'b10:   count_d = count_q + FIRST;
                    2'b01:   count_d = count_q - FIRST;
                    default: count_d = count_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy_q         <= '0;
            ready_q        <= '0;
            for (int i = 0; i < NENT; i++) ent_q[i] <= '0;
            head_q         <= FIRST;
            tail_q         <= FIRST;
            count_q        <= '0;
            commit_ready_q <= 1'b0;
            commit_id_q    <= '0;
            commit_reg_q   <= '0;
            commit_value_q <= '0;
            clear_q        <= 1'b0;
            clear_pc_q     <= '0;
        end else begin
            busy_q         <= busy_d;
            ready_q        <= ready_d;
            ent_q          <= ent_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            commit_ready_q <= commit_ready_d;
            commit_id_q    <= commit_id_d;
            commit_reg_q   <= commit_reg_d;
            commit_value_q <= commit_value_d;
            clear_q        <= clear_d;
            clear_pc_q     <= clear_pc_d;
        end
    end

`ifdef ROB_PERF_COUNTERS_EN
    logic [31:0] perf_commits_q, perf_commits_d, perf_flushes_q, perf_flushes_d;

    always_comb begin
        perf_commits_d = perf_commits_q + {31'h0, commit_go};
        perf_flushes_d = perf_flushes_q + {31'h0, mispredict};
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            perf_commits_q <= '0;
            perf_flushes_q <= '0;
        end else begin
            perf_commits_q <= perf_commits_d;
            perf_flushes_q <= perf_flushes_d;
        end
    end

    assign _perf_commits = perf_commits_q;
    assign _perf_flushes = perf_flushes_q;
`endif
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: issue/launch, ordering, full/wrap, mispredict flush, queries, stall, async reset.
module tb_reorder_buffer;
    logic        clk_in = 1'b0, rst_in = 1'b1, rdy_in = 1'b1;
    logic        issue_valid = 0, issue_is_branch = 0, issue_pred_taken = 0;
    logic [4:0]  issue_rd = 0;
    logic        rob_full, launch_ready, wb_valid = 0, wb_taken = 0;
    logic [4:0]  tail_id, launch_rob_id, launch_reg, commit_id, commit_reg, wb_id = 0, q_id1 = 0, q_id2 = 0;
    logic [31:0] wb_value = 0, wb_target = 0, q_val1, q_val2, commit_value, clear_pc;
    logic        q_rdy1, q_rdy2, commit_ready, clear;
    int          checks = 0, fails = 0;

    always #5 clk_in = ~clk_in;

    reorder_buffer dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        ._issue_valid(issue_valid), ._issue_rd(issue_rd),
        ._issue_is_branch(issue_is_branch), ._issue_pred_taken(issue_pred_taken),
        ._rob_full(rob_full), ._rob_tail_id(tail_id),
        ._rob_launch_ready(launch_ready), ._rob_launch_rob_id(launch_rob_id),
        ._rob_launch_register_id(launch_reg),
        ._wb_valid(wb_valid), ._wb_rob_id(wb_id), ._wb_value(wb_value),
        ._wb_taken(wb_taken), ._wb_target(wb_target),
        ._query_id_1(q_id1), ._query_ready_1(q_rdy1), ._query_value_1(q_val1),
        ._query_id_2(q_id2), ._query_ready_2(q_rdy2), ._query_value_2(q_val2),
        ._rob_commit_ready(commit_ready), ._rob_commit_rob_id(commit_id),
        ._rob_commit_register_id(commit_reg), ._rob_commit_value(commit_value),
        ._clear(clear), ._clear_pc(clear_pc)
    );

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        issue_valid = 0; issue_is_branch = 0; issue_pred_taken = 0; issue_rd = 0;
        wb_valid = 0; wb_taken = 0; wb_id = 0; wb_value = 0; wb_target = 0; rdy_in = 1;
        @(negedge clk_in);
        rst_in = 1;
        #2;
        rst_in = 0;
        step();
    endtask

    task automatic test_reset();
        rst_in = 1;
        #12;
        checks++; if (commit_ready !== 1'b0) begin fails++; $display("FAIL reset_commit_ready got=%b exp=0", commit_ready); end
        checks++; if (clear !== 1'b0 || clear_pc !== 32'h0) begin fails++; $display("FAIL reset_clear got=%b/%h exp=0/0", clear, clear_pc); end
        checks++; if (tail_id !== 5'd1 || rob_full !== 1'b0) begin fails++; $display("FAIL reset_tail got=%0d full=%b exp=1/0", tail_id, rob_full); end
        checks++; if (commit_id !== 5'd0 || commit_value !== 32'h0) begin fails++; $display("FAIL reset_commit_fields got=%0d/%h exp=0/0", commit_id, commit_value); end
        do_reset();
    endtask

    task automatic test_basic();
        issue_valid = 1; issue_rd = 5;
        #1;
        checks++; if (launch_ready !== 1'b1 || launch_rob_id !== 5'd1 || launch_reg !== 5'd5) begin fails++; $display("FAIL basic_launch got=%b/%0d/%0d exp=1/1/5", launch_ready, launch_rob_id, launch_reg); end
        step();
        issue_valid = 0;
        wb_valid = 1; wb_id = 1; wb_value = 32'hDEAD;
        step();
        wb_valid = 0;
        checks++; if (commit_ready !== 1'b0) begin fails++; $display("FAIL basic_no_bypass got=%b exp=0", commit_ready); end
        step();
        checks++; if (commit_ready !== 1'b1 || commit_id !== 5'd1 || commit_reg !== 5'd5 || commit_value !== 32'hDEAD) begin fails++; $display("FAIL basic_commit got=%b/%0d/%0d/%h exp=1/1/5/dead", commit_ready, commit_id, commit_reg, commit_value); end
        step();
        checks++; if (commit_ready !== 1'b0 || tail_id !== 5'd2 || rob_full !== 1'b0) begin fails++; $display("FAIL basic_after got=%b/%0d/%b exp=0/2/0", commit_ready, tail_id, rob_full); end
    endtask

    task automatic test_full_wrap();
        do_reset();
        issue_valid = 1;
        for (int i = 1; i <= 31; i++) begin
            issue_rd = 5'(i);
            step();
        end
        checks++; if (rob_full !== 1'b1 || tail_id !== 5'd1) begin fails++; $display("FAIL full_flag got=%b tail=%0d exp=1/1", rob_full, tail_id); end
        #1;
        checks++; if (launch_ready !== 1'b0) begin fails++; $display("FAIL full_no_launch got=%b exp=0", launch_ready); end
        issue_valid = 0;
        wb_valid = 1; wb_id = 1; wb_value = 32'h1234;
        step();
        wb_valid = 0;
        step();
        checks++; if (commit_ready !== 1'b1 || commit_id !== 5'd1 || commit_reg !== 5'd1 || rob_full !== 1'b0) begin fails++; $display("FAIL full_commit got=%b/%0d/%0d full=%b exp=1/1/1/0", commit_ready, commit_id, commit_reg, rob_full); end
        issue_valid = 1; issue_rd = 9;
        #1;
        checks++; if (launch_ready !== 1'b1 || launch_rob_id !== 5'd1) begin fails++; $display("FAIL wrap_launch got=%b/%0d exp=1/1", launch_ready, launch_rob_id); end
        step();
        issue_valid = 0;
        checks++; if (rob_full !== 1'b1 || tail_id !== 5'd2) begin fails++; $display("FAIL wrap_refill got=%b/%0d exp=1/2", rob_full, tail_id); end
    endtask

    task automatic test_in_order();
        do_reset();
        issue_valid = 1;
        for (int i = 1; i <= 3; i++) begin
            issue_rd = 5'(i + 10);
            step();
        end
        issue_valid = 0;
        wb_valid = 1;
        for (int i = 3; i >= 1; i--) begin
            wb_id = 5'(i); wb_value = 32'(i * 16'h11);
            step();
        end
        wb_valid = 0;
        checks++; if (commit_ready !== 1'b0) begin fails++; $display("FAIL order_wait got=%b exp=0", commit_ready); end
        for (int i = 1; i <= 3; i++) begin
            step();
            checks++; if (commit_ready !== 1'b1 || commit_id !== 5'(i) || commit_reg !== 5'(i + 10) || commit_value !== 32'(i * 16'h11)) begin fails++; $display("FAIL order_commit%0d got=%b/%0d/%0d/%h", i, commit_ready, commit_id, commit_reg, commit_value); end
        end
        step();
        checks++; if (commit_ready !== 1'b0) begin fails++; $display("FAIL order_drained got=%b exp=0", commit_ready); end
    endtask

    task automatic test_mispredict();
        do_reset();
        issue_valid = 1; issue_rd = 0; issue_is_branch = 1; issue_pred_taken = 0;
        step();
        issue_is_branch = 0; issue_rd = 7;
        step();
        issue_valid = 0;
        wb_valid = 1; wb_id = 1; wb_taken = 1; wb_target = 32'h100; wb_value = 0;
        step();
        wb_valid = 0;
        step();
        checks++; if (commit_ready !== 1'b1 || commit_id !== 5'd1 || clear !== 1'b1 || clear_pc !== 32'h100) begin fails++; $display("FAIL mp_pulse got=%b/%0d clr=%b pc=%h exp=1/1/1/100", commit_ready, commit_id, clear, clear_pc); end
        issue_valid = 1; issue_rd = 3;
        wb_valid = 1; wb_id = 2; wb_value = 32'h77; wb_taken = 0;
        #1;
        checks++; if (launch_ready !== 1'b0) begin fails++; $display("FAIL mp_issue_blocked got=%b exp=0", launch_ready); end
        step();
        wb_valid = 0;
        checks++; if (clear !== 1'b0 || commit_ready !== 1'b0 || tail_id !== 5'd1) begin fails++; $display("FAIL mp_flushed got=%b/%b/%0d exp=0/0/1", clear, commit_ready, tail_id); end
        checks++; if (launch_ready !== 1'b1 || launch_rob_id !== 5'd1) begin fails++; $display("FAIL mp_relaunch got=%b/%0d exp=1/1", launch_ready, launch_rob_id); end
        issue_valid = 0;
        step();
        checks++; if (commit_ready !== 1'b0) begin fails++; $display("FAIL mp_no_stale_commit got=%b exp=0", commit_ready); end
    endtask

    task automatic test_query_stall();
        do_reset();
        issue_valid = 1;
        for (int i = 1; i <= 4; i++) begin
            issue_rd = 5'(i);
            step();
        end
        issue_valid = 0;
        wb_valid = 1; wb_id = 4; wb_value = 7;
        step();
        q_id1 = 4; q_id2 = 0;
        wb_id = 3; wb_value = 9;
        #1;
        checks++; if (q_rdy1 !== 1'b1 || q_val1 !== 32'd7) begin fails++; $display("FAIL query_id4 got=%b/%0d exp=1/7", q_rdy1, q_val1); end
        checks++; if (q_rdy2 !== 1'b0 || q_val2 !== 32'd0) begin fails++; $display("FAIL query_id0 got=%b/%0d exp=0/0", q_rdy2, q_val2); end
        q_id2 = 3;
        #1;
        checks++; if (q_rdy2 !== 1'b0) begin fails++; $display("FAIL query_no_forward got=%b exp=0", q_rdy2); end
        step();
        checks++; if (q_rdy2 !== 1'b1 || q_val2 !== 32'd9) begin fails++; $display("FAIL query_id3 got=%b/%0d exp=1/9", q_rdy2, q_val2); end
        wb_id = 1; wb_value = 32'h11;
        step();
        wb_valid = 0;
        rdy_in = 0; issue_valid = 1; issue_rd = 20;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (commit_ready !== 1'b0 || tail_id !== 5'd5 || launch_ready !== 1'b0) begin fails++; $display("FAIL stall_hold%0d got=%b/%0d/%b exp=0/5/0", i, commit_ready, tail_id, launch_ready); end
        end
        issue_valid = 0; rdy_in = 1;
        step();
        checks++; if (commit_ready !== 1'b1 || commit_id !== 5'd1 || commit_value !== 32'h11) begin fails++; $display("FAIL stall_resume got=%b/%0d/%h exp=1/1/11", commit_ready, commit_id, commit_value); end
        step();
        checks++; if (commit_ready !== 1'b0) begin fails++; $display("FAIL stall_head2_pending got=%b exp=0", commit_ready); end
        q_id1 = 0; q_id2 = 0;
    endtask

    task automatic test_async_reset();
        do_reset();
        issue_valid = 1;
        for (int i = 1; i <= 5; i++) begin
            issue_rd = 5'(i);
            step();
        end
        issue_valid = 0;
        wb_valid = 1; wb_id = 1; wb_value = 32'h55;
        step();
        wb_valid = 0;
        step();
        checks++; if (commit_ready !== 1'b1 || commit_value !== 32'h55) begin fails++; $display("FAIL ar_precommit got=%b/%h exp=1/55", commit_ready, commit_value); end
        #2;
        rst_in = 1;
        #1;
        checks++; if (commit_ready !== 1'b0 || commit_value !== 32'h0 || commit_id !== 5'd0 || tail_id !== 5'd1) begin fails++; $display("FAIL ar_immediate got=%b/%h/%0d/%0d exp=0/0/0/1", commit_ready, commit_value, commit_id, tail_id); end
        #1;
        rst_in = 0;
        issue_valid = 1; issue_rd = 6;
        #1;
        checks++; if (launch_ready !== 1'b1 || launch_rob_id !== 5'd1) begin fails++; $display("FAIL ar_relaunch got=%b/%0d exp=1/1", launch_ready, launch_rob_id); end
        step();
        issue_valid = 0;
        checks++; if (tail_id !== 5'd2) begin fails++; $display("FAIL ar_tail got=%0d exp=2", tail_id); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_wrap();
        test_in_order();
        test_mispredict();
        test_query_stall();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
